// File: rtl/seg_disp_sched.sv
// seg_disp_sched
// Shares the six-digit seven-segment display between three requesters.
// A round-robin arbiter picks one source and locks it for at least HOLD_MAX
// cycles. The granted source's value, sign and decimal-point mask are then
// registered onto the data_trans / hc595_ctrl datapath inputs. Values above
// 999_999 are clamped. The last shown value is kept while nobody requests.
//
// Ports
//   clk                 system clock (50 MHz)
//   rst_n               asynchronous active-low reset
//   req[2:0]            level-sensitive requests, bit i = requester i
//   data0/1/2[19:0]     unsigned value of each requester
//   sign0/1/2           1 = show minus sign
//   point0/1/2[5:0]     decimal-point mask of each requester
//   gnt[2:0]            one-hot grant, 3'b000 when idle
//   data[19:0]          saturated value to data_trans (0..999_999)
//   sign                sign to data_trans
//   point[5:0]          point mask to data_trans
//   busy                1 while any grant is active
module seg_disp_sched #(
  parameter logic [24:0] HOLD_MAX = 25'd25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [19:0] data0,
  input  logic [19:0] data1,
  input  logic [19:0] data2,
  input  logic        sign0,
  input  logic        sign1,
  input  logic        sign2,
  input  logic [5:0]  point0,
  input  logic [5:0]  point1,
  input  logic [5:0]  point2,
  output logic [2:0]  gnt,
  output logic [19:0] data,
  output logic        sign,
  output logic [5:0]  point,
  output logic        busy
);

  localparam logic [19:0] DISP_MAX = 20'd999_999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_OPEN = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  r_gnt;
  logic [1:0]  r_last;
  logic [24:0] r_cnt;
  logic        r_busy;
  logic [19:0] r_data;
  logic        r_sign;
  logic [5:0]  r_point;

  logic [1:0]  w_pick_all;
  logic [1:0]  w_pick_oth;
  logic [2:0]  w_req_oth;
  logic [19:0] w_sel_data;
  logic        w_sel_sign;
  logic [5:0]  w_sel_point;
  logic [19:0] w_sat_data;

  // First set bit scanning last+1, last+2, last+3 (mod 3). Scanning in reverse
  // and overwriting lets the earliest position in the order win.
  function automatic logic [1:0] rr_pick(input logic [2:0] req_v, input logic [1:0] last);
    logic [2:0] s;
    logic [1:0] cand;
    rr_pick = 2'd0;
    for (int i = 3; i >= 1; i--) begin
      s = {1'b0, last} + 3'(i);
      if (s >= 3'd3) begin
        cand = 2'(s - 3'd3);
      end else begin
        cand = s[1:0];
      end
      if (req_v[cand]) begin
        rr_pick = cand;
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    onehot = 3'b001 << idx;
  endfunction

  // In OPEN the current owner equals r_last, so masking it out leaves the
  // other requesters in round-robin order.
  assign w_req_oth  = req & ~r_gnt;
  assign w_pick_all = rr_pick(req, r_last);
  assign w_pick_oth = rr_pick(w_req_oth, r_last);

  // Source mux driven by the registered grant: outputs lag gnt by one cycle.
  always_comb begin
    w_sel_data  = 20'd0;
    w_sel_sign  = 1'b0;
    w_sel_point = 6'd0;
    case (r_gnt)
      3'b001: begin
        w_sel_data  = data0;
        w_sel_sign  = sign0;
        w_sel_point = point0;
      end
      3'b010: begin
        w_sel_data  = data1;
        w_sel_sign  = sign1;
        w_sel_point = point1;
      end
      3'b100: begin
        w_sel_data  = data2;
        w_sel_sign  = sign2;
        w_sel_point = point2;
      end
      default: begin
        w_sel_data  = 20'd0;
        w_sel_sign  = 1'b0;
        w_sel_point = 6'd0;
      end
    endcase
  end

  assign w_sat_data = (w_sel_data > DISP_MAX) ? DISP_MAX : w_sel_data;

  // Arbitration FSM: grant, dwell counter, round-robin pointer and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= 3'b000;
      r_last  <= 2'd2;
      r_cnt   <= 25'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req != 3'b000) begin
            r_gnt   <= onehot(w_pick_all);
            r_last  <= w_pick_all;
            r_cnt   <= 25'd0;
            r_busy  <= 1'b1;
            r_state <= ST_HOLD;
          end else begin
            r_gnt  <= 3'b000;
            r_busy <= 1'b0;
          end
        end
        ST_HOLD: begin
          // Counter saturates at HOLD_MAX-1 and stays there through OPEN.
          if (r_cnt == HOLD_MAX - 25'd1) begin
            r_state <= ST_OPEN;
          end else begin
            r_cnt <= r_cnt + 25'd1;
          end
        end
        ST_OPEN: begin
          if (w_req_oth != 3'b000) begin
            r_gnt   <= onehot(w_pick_oth);
            r_last  <= w_pick_oth;
            r_cnt   <= 25'd0;
            r_busy  <= 1'b1;
            r_state <= ST_HOLD;
          end else if ((req & r_gnt) != 3'b000) begin
            r_state <= ST_OPEN;
          end else begin
            r_gnt   <= 3'b000;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_gnt   <= 3'b000;
          r_busy  <= 1'b0;
          r_cnt   <= 25'd0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Display datapath: track the granted source live, freeze when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= 20'd0;
      r_sign  <= 1'b0;
      r_point <= 6'd0;
    end else if (r_gnt != 3'b000) begin
      r_data  <= w_sat_data;
      r_sign  <= w_sel_sign;
      r_point <= w_sel_point;
    end else begin
      r_data  <= r_data;
      r_sign  <= r_sign;
      r_point <= r_point;
    end
  end

  assign gnt   = r_gnt;
  assign busy  = r_busy;
  assign data  = r_data;
  assign sign  = r_sign;
  assign point = r_point;

endmodule

// File: tb/tb_seg_disp_sched.sv
module tb_seg_disp_sched;

  typedef struct packed {
    logic [2:0]  gnt;
    logic [19:0] data;
    logic        sign;
    logic [5:0]  point;
    logic        busy;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [19:0] data0, data1, data2;
  logic        sign0, sign1, sign2;
  logic [5:0]  point0, point1, point2;
  logic [2:0]  gnt;
  logic [19:0] data;
  logic        sign;
  logic [5:0]  point;
  logic        busy;

  int   checks;
  int   errors;
  exp_t q[$];
  exp_t e;
  exp_t obs;

  seg_disp_sched #(.HOLD_MAX(25'd4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .sign0(sign0), .sign1(sign1), .sign2(sign2),
    .point0(point0), .point1(point1), .point2(point2),
    .gnt(gnt), .data(data), .sign(sign), .point(point), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb obs = {gnt, data, sign, point, busy};

  function automatic exp_t mk(input logic [2:0] g, input logic [19:0] d,
                              input logic s, input logic [5:0] p, input logic b);
    mk = {g, d, s, p, b};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req = 3'b000;
    data0 = 20'd0; data1 = 20'd0; data2 = 20'd0;
    sign0 = 1'b0;  sign1 = 1'b0;  sign2 = 1'b0;
    point0 = 6'd0; point1 = 6'd0; point2 = 6'd0;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    q.push_back(mk(3'b000, 20'd0, 1'b0, 6'd0, 1'b0));
    e = q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_async: got %h want %h", obs, e);
    end
    req = 3'b111;
    data0 = 20'd9;
    q.push_back(mk(3'b000, 20'd0, 1'b0, 6'd0, 1'b0));
    step();
    e = q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_held: got %h want %h", obs, e);
    end
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_grant;
    apply_reset();
    req = 3'b001; data0 = 20'd123456; point0 = 6'b001010;
    q.push_back(mk(3'b001, 20'd0, 1'b0, 6'd0, 1'b1));
    q.push_back(mk(3'b001, 20'd123456, 1'b0, 6'b001010, 1'b1));
    for (int c = 0; q.size() > 0; c++) begin
      step();
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL first_grant cyc %0d: got gnt=%b data=%0d sign=%b point=%b busy=%b want gnt=%b data=%0d sign=%b point=%b busy=%b",
                 c, gnt, data, sign, point, busy, e.gnt, e.data, e.sign, e.point, e.busy);
      end
    end
  endtask

  task automatic test_round_robin;
    logic [19:0] sd [3];
    logic        ss [3];
    logic [5:0]  sp [3];
    logic [2:0]  g;
    int          prev;
    int          cur;
    apply_reset();
    sd[0] = 20'd10; sd[1] = 20'd11; sd[2] = 20'd12;
    ss[0] = 1'b0;   ss[1] = 1'b1;   ss[2] = 1'b0;
    sp[0] = 6'd1;   sp[1] = 6'd2;   sp[2] = 6'd4;
    data0 = sd[0]; data1 = sd[1]; data2 = sd[2];
    sign0 = ss[0]; sign1 = ss[1]; sign2 = ss[2];
    point0 = sp[0]; point1 = sp[1]; point2 = sp[2];
    req = 3'b111;
    prev = -1;
    for (int i = 0; i < 20; i++) begin
      cur = (i / 5) % 3;
      g = 3'b001 << cur;
      if (prev < 0) begin
        q.push_back(mk(g, 20'd0, 1'b0, 6'd0, 1'b1));
      end else begin
        q.push_back(mk(g, sd[prev], ss[prev], sp[prev], 1'b1));
      end
      prev = cur;
    end
    for (int c = 0; q.size() > 0; c++) begin
      step();
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL round_robin cyc %0d: got gnt=%b data=%0d sign=%b point=%b busy=%b want gnt=%b data=%0d sign=%b point=%b busy=%b",
                 c, gnt, data, sign, point, busy, e.gnt, e.data, e.sign, e.point, e.busy);
      end
    end
  endtask

  task automatic test_hold_ignores_drop;
    apply_reset();
    req = 3'b010; data1 = 20'd777; sign1 = 1'b1; point1 = 6'b100001;
    q.push_back(mk(3'b010, 20'd0, 1'b0, 6'd0, 1'b1));
    for (int i = 1; i < 5; i++) q.push_back(mk(3'b010, 20'd777, 1'b1, 6'b100001, 1'b1));
    q.push_back(mk(3'b000, 20'd777, 1'b1, 6'b100001, 1'b0));
    q.push_back(mk(3'b000, 20'd777, 1'b1, 6'b100001, 1'b0));
    for (int c = 0; q.size() > 0; c++) begin
      step();
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL hold_drop cyc %0d: got gnt=%b data=%0d sign=%b point=%b busy=%b want gnt=%b data=%0d sign=%b point=%b busy=%b",
                 c, gnt, data, sign, point, busy, e.gnt, e.data, e.sign, e.point, e.busy);
      end
      if (c == 1) req = 3'b000;
      if (c == 5) data1 = 20'd555;
    end
  endtask

  task automatic test_saturation;
    apply_reset();
    req = 3'b100; data2 = 20'd1_048_575; sign2 = 1'b1; point2 = 6'b111111;
    q.push_back(mk(3'b100, 20'd0, 1'b0, 6'd0, 1'b1));
    q.push_back(mk(3'b100, 20'd999_999, 1'b1, 6'b111111, 1'b1));
    q.push_back(mk(3'b100, 20'd42, 1'b1, 6'b111111, 1'b1));
    q.push_back(mk(3'b100, 20'd1_000_000 - 20'd1, 1'b1, 6'b111111, 1'b1));
    for (int c = 0; q.size() > 0; c++) begin
      step();
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL saturation cyc %0d: got gnt=%b data=%0d sign=%b point=%b busy=%b want gnt=%b data=%0d sign=%b point=%b busy=%b",
                 c, gnt, data, sign, point, busy, e.gnt, e.data, e.sign, e.point, e.busy);
      end
      if (c == 1) data2 = 20'd42;
      if (c == 2) data2 = 20'd1_000_000;
    end
  endtask

  task automatic test_async_reset;
    apply_reset();
    req = 3'b010; data1 = 20'd321; sign1 = 1'b1; point1 = 6'b010000;
    q.push_back(mk(3'b010, 20'd0, 1'b0, 6'd0, 1'b1));
    q.push_back(mk(3'b010, 20'd321, 1'b1, 6'b010000, 1'b1));
    for (int c = 0; q.size() > 0; c++) begin
      step();
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL async_pre cyc %0d: got %h want %h", c, obs, e);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    q.push_back(mk(3'b000, 20'd0, 1'b0, 6'd0, 1'b0));
    e = q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL async_reset: got gnt=%b data=%0d sign=%b point=%b busy=%b want all zero",
               gnt, data, sign, point, busy);
    end
    req = 3'b011; data0 = 20'd64;
    @(negedge clk);
    rst_n = 1'b1;
    q.push_back(mk(3'b001, 20'd0, 1'b0, 6'd0, 1'b1));
    q.push_back(mk(3'b001, 20'd64, 1'b0, 6'd0, 1'b1));
    for (int c = 0; q.size() > 0; c++) begin
      step();
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL async_post cyc %0d: got gnt=%b data=%0d want gnt=%b data=%0d",
                 c, gnt, data, e.gnt, e.data);
      end
    end
  endtask

  task automatic test_back_to_back;
    apply_reset();
    req = 3'b001; data0 = 20'd5; data2 = 20'd9; point2 = 6'b000100;
    q.push_back(mk(3'b001, 20'd0, 1'b0, 6'd0, 1'b1));
    for (int i = 1; i < 5; i++) q.push_back(mk(3'b001, 20'd5, 1'b0, 6'd0, 1'b1));
    q.push_back(mk(3'b100, 20'd5, 1'b0, 6'd0, 1'b1));
    q.push_back(mk(3'b100, 20'd9, 1'b0, 6'b000100, 1'b1));
    for (int c = 0; q.size() > 0; c++) begin
      step();
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: got gnt=%b data=%0d point=%b busy=%b want gnt=%b data=%0d point=%b busy=%b",
                 c, gnt, data, point, busy, e.gnt, e.data, e.point, e.busy);
      end
      if (c == 0) req = 3'b101;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clear_inputs();
    test_reset();
    test_first_grant();
    test_round_robin();
    test_hold_ignores_drop();
    test_saturation();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
